// File: rtl/decoder_2_4_seq.sv
`timescale 1ns/1ps
// decoder_2_4_seq
// Receiving end of the 4-to-2 encoder path. 2-bit codes are accepted on a
// valid/ready port and queued in a small FIFO. Each code is replayed as a
// one-hot strobe on y for HOLD cycles, followed by one all-zero gap cycle,
// so back-to-back strobes never merge. Enable e only gates the start of a
// new strobe; input acceptance and in-progress strobes are unaffected.
module decoder_2_4_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic [1:0] a,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] y,
    output logic       y_valid,
    output logic       busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);
    localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    y_q, y_d;
    logic          y_valid_q, y_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          push_s;
    logic          pop_s;

    // Handshake qualifiers: a full FIFO refuses pushes even when a pop frees a slot on the same edge.
    always_comb begin
        push_s = in_valid && (count_q != CNT_FULL);
        pop_s  = (state_q == S_IDLE) && e && (count_q != CNT_ZERO);
    end

    // FIFO storage, pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = a;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Strobe sequencer: IDLE pops and loads the pattern, DRIVE holds it, GAP forces one zero cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    y_d     = 4'b0001 << mem_q[rd_ptr_q];
                    hold_d  = HOLD_LOAD;
                    state_d = S_DRIVE;
                end else begin
                    y_d     = 4'b0000;
                end
            end
            S_DRIVE: begin
                if (hold_q == HOLD_ZERO) begin
                    y_d     = 4'b0000;
                    state_d = S_GAP;
                end else begin
                    hold_d  = hold_q - 1'b1;
                end
            end
            S_GAP: begin
                y_d     = 4'b0000;
                state_d = S_IDLE;
            end
            default: begin
                y_d     = 4'b0000;
                hold_d  = HOLD_ZERO;
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are computed from next-state so they register alongside the state they describe.
    always_comb begin
        y_valid_d  = |y_d;
        in_ready_d = (count_d != CNT_FULL);
        busy_d     = (count_d != CNT_ZERO) || (state_d != S_IDLE);
    end

    // State and output registers; reset clears the queue and the strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= CNT_ZERO;
            state_q    <= S_IDLE;
            hold_q     <= HOLD_ZERO;
            y_q        <= 4'b0000;
            y_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_decoder_2_4_seq.sv
`timescale 1ns/1ps
// Bench for decoder_2_4_seq: directed scenarios plus random traffic, all
// checked every cycle against a queue-and-timer reference model.
module tb_decoder_2_4_seq;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       e;
    logic [1:0] a;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] y;
    logic       y_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending codes, and cycles left in the current strobe
    // (HOLD drive cycles followed by one gap cycle).
    int mq[$];
    int timer    = 0;
    int cur      = 0;
    bit last_acc = 1'b0;

    always #5 clk = ~clk;

    decoder_2_4_seq #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .e        (e),
        .a        (a),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .y_valid  (y_valid),
        .busy     (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        timer = 0;
        cur   = 0;
    endtask

    task automatic check_outputs();
        logic [3:0] ey;
        ey = (timer > 1) ? 4'(1 << cur) : 4'b0000;
        check_eq("y", 32'(y), 32'(ey));
        check_eq("y_valid", 32'(y_valid), 32'(timer > 1));
        check_eq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        check_eq("busy", 32'(busy), 32'((mq.size() > 0) || (timer > 0)));
        check_eq("onehot0", 32'((y == 4'b0000) || $onehot(y)), 32'd1);
        check_eq("yv_eq_or", 32'(y_valid), 32'(|y));
    endtask

    // One clock: advance the model with the inputs present at the edge, then check.
    task automatic step();
        logic       ve;
        logic       vv;
        logic [1:0] va;
        int         sz;
        ve = e;
        vv = in_valid;
        va = a;
        @(posedge clk);
        sz       = mq.size();
        last_acc = vv && (sz < DEPTH);
        if (timer > 0) begin
            timer--;
        end else if (ve && sz > 0) begin
            cur   = mq.pop_front();
            timer = HOLD + 1;
        end
        if (last_acc) mq.push_back(int'(va));
        #1;
        check_outputs();
    endtask

    task automatic push_code(input logic [1:0] code);
        a        = code;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (last_acc) return;
        end
        check_eq("push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; e = 1'b0; a = 2'b00; in_valid = 1'b0;
        #2;
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_yv", 32'(y_valid), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Single code 10: strobe after next edge, held two cycles, gap, idle.
        e = 1'b1;
        push_code(2'b10);
        in_valid = 1'b0;
        step(); check_eq("s1_y_on1", 32'(y), 32'h4);
        step(); check_eq("s1_y_on2", 32'(y), 32'h4);
        step(); check_eq("s1_y_gap", 32'(y), 32'h0);
        check_eq("s1_busy_gap", 32'(busy), 32'd1);
        step(); check_eq("s1_busy_off", 32'(busy), 32'd0);
        repeat (2) step();

        // Four codes back to back.
        for (int i = 0; i < 4; i++) push_code(2'(i));
        in_valid = 1'b0;
        repeat (16) step();

        // Fill with e low, fifth code held off until a slot frees.
        e = 1'b0;
        push_code(2'b11); push_code(2'b10); push_code(2'b01); push_code(2'b00);
        a = 2'b11; in_valid = 1'b1;
        repeat (3) step();
        check_eq("s3_full_ready", 32'(in_ready), 32'd0);
        check_eq("s3_y_idle", 32'(y), 32'd0);
        e = 1'b1;
        for (int i = 0; i < 20 && !last_acc; i++) step();
        check_eq("s3_fifth_acc", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        repeat (25) step();

        // Drop e during the first drive cycle of 01 with 10 queued.
        push_code(2'b01);
        push_code(2'b10);
        in_valid = 1'b0;
        check_eq("s4_y_first", 32'(y), 32'h2);
        e = 1'b0;
        repeat (8) step();
        check_eq("s4_held_y", 32'(y), 32'd0);
        check_eq("s4_held_busy", 32'(busy), 32'd1);
        e = 1'b1;
        repeat (10) step();

        // Async reset mid-strobe with two codes queued.
        push_code(2'b10); push_code(2'b00); push_code(2'b01);
        in_valid = 1'b0;
        check_eq("s5_y_pre", 32'(y), 32'h4);
        #3 rst = 1'b1;
        #1;
        check_eq("s5_rst_y", 32'(y), 32'd0);
        check_eq("s5_rst_ready", 32'(in_ready), 32'd1);
        check_eq("s5_rst_busy", 32'(busy), 32'd0);
        model_reset();
        #1 rst = 1'b0;
        repeat (10) step();

        // Random traffic; source holds its code while not accepted.
        last_acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(3) != 0);
            if (!in_valid || last_acc) begin
                in_valid = $urandom_range(1);
                a        = 2'($urandom_range(3));
            end
            step();
        end
        in_valid = 1'b0;
        e = 1'b1;
        repeat (30) step();
        check_eq("drain_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
